me_full_search: RTL and testbench
=================================

Name: me_full_search

Overview:
- Parametrised full-search integer motion-estimation engine. Successor to the fixed 16x16 `me` block.
- Loads one current block, then consumes candidate block rows for every position in the search window.
- Outputs the minimum SAD, its signed motion vector, and an early-termination flag.
- Sits between the reference-frame fetcher (search rows) and the mode-decision stage (results).

Parameters:
BLK_DIM, 16, block edge in pixels (power of two, >= 4)
SEARCH_DIM, 48, search window edge in pixels; (SEARCH_DIM-BLK_DIM) must be even
PIXEL_W, 8, bits per pixel

Derived (package functions):
- N = SEARCH_DIM-BLK_DIM+1 (candidates per axis)
- RANGE = (N-1)/2
- SAD_W = PIXEL_W+2*clog2(BLK_DIM)
- MV_W = clog2(N)+1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a search; honoured only while ready=1
ready  out  1  engine idle, can accept start
early_thr  in  SAD_W  early-termination threshold, sampled on accepted start; 0 = disabled
cur_valid  in  1  current-block row beat valid
cur_ready  out  1  engine accepts current rows
cur_row  in  BLK_DIM*PIXEL_W  one current-block row, pixel 0 in LSBs
srch_valid  in  1  candidate row beat valid
srch_ready  out  1  engine accepts candidate rows
srch_row  in  BLK_DIM*PIXEL_W  one candidate row, pixel 0 in LSBs
valid  out  1  one-cycle result pulse
min_sad  out  SAD_W  best SAD
mv_x  out  MV_W  signed horizontal vector, dx-RANGE
mv_y  out  MV_W  signed vertical vector, dy-RANGE
early_stop  out  1  search ended by threshold

Behaviour:
- Reset values: ready=1, cur_ready=0, srch_ready=0, valid=0, min_sad=0, mv_x=0, mv_y=0, early_stop=0, FSM=IDLE. Reset at any point aborts the search, clears the pipeline and returns to IDLE on the next edge.
- FSM states: IDLE -> LOAD -> SEARCH -> DRAIN -> DONE -> IDLE.
- IDLE: ready=1. start=1 captures early_thr, sets min register to all-ones, clears counters, goes to LOAD. start in any other state is ignored.
- LOAD:
  - cur_ready=1.
  - Each cur_valid&cur_ready beat stores the next row, row 0 = top.
  - After BLK_DIM beats, go to SEARCH.
- SEARCH:
  - srch_ready=1.
  - Beat order: candidates raster (dy outer, dx inner, both 0..N-1), rows 0..BLK_DIM-1 within each candidate.
  - Pixel j of row r of candidate (dx,dy) = window pixel (dy+r, dx+j).
  - Counters r, dx, dy advance only on a handshake. srch_valid low inserts a bubble.
- Pipeline:
  - Stage 1 registers the row SAD (sum of |cur-cand| over BLK_DIM pixels, unsigned, SAD_W bits, no overflow possible) plus last-row flag and dx/dy tags.
  - Stage 2 accumulates. On last row: cand = acc+rowsad; if cand < min (strict), update min, dx, dy; acc cleared.
  - Tie rule: the first candidate in raster order wins.
- Early termination:
  - Applies when early_thr != 0 and the updated min <= early_thr at a candidate's final row.
  - Sets early_stop=1 and goes to DONE on that edge. srch_ready drops on the same edge.
  - Beats accepted in the 2 cycles between that candidate's final beat and the decision are discarded and never affect results.
  - The upstream fetcher abandons the rest of the window on seeing early_stop.
- Normal end: when the beat for (N-1,N-1,BLK_DIM-1) is accepted, go to DRAIN with srch_ready=0. When stage 2 completes, go to DONE.
- DONE:
  - valid=1 for exactly one cycle, then IDLE.
  - On the non-early path, valid is high in the cycle after the second edge following the final beat.
  - min_sad, mv_x, mv_y, early_stop are stable from valid until the next accepted start.
- mv_x = dx-RANGE, mv_y = dy-RANGE, two's complement, range -RANGE..+RANGE.

Decomposition:
- Package me_pkg: derived-width functions (n_cand, sad_w, mv_w, range), state enum, pixel type.
- Sub-module me_row_sad: combinational absolute differences over BLK_DIM pixels plus balanced adder tree, outputs SAD_W. me_full_search registers its output as stage 1.

Test Plan:
1. BLK_DIM=4, SEARCH_DIM=8, thr=0; current block equals window at (dx=3,dy=1), all other candidates differ -> after 100 beats: min_sad=0, mv_x=+1, mv_y=-1, early_stop=0, valid 2 edges after the last beat.
2. Same config; candidates (0,0) and (4,4) both SAD=12, all others larger -> mv=(-2,-2), min_sad=12.
3. Same config, thr=10; first SAD<=10 at candidate (2,1) with SAD=5 -> early_stop=1, mv=(0,-1), min_sad=5, srch_ready=0 after the decision edge, trailing beats ignored.
4. Scenario 1 with random srch_valid and cur_valid gaps (50% duty) -> identical results to scenario 1; valid pulses once.
5. Reset asserted mid-SEARCH, then scenario 1 rerun -> outputs zero during reset, ready=1 after, rerun results match scenario 1; start during SEARCH is ignored.
6. Defaults (16/48): current all 255, window all 0 -> min_sad=65280, mv=(-16,-16), valid after 1089*16 beats.

Source files
------------

// File: rtl/me_pkg.sv
// me_pkg: derived widths, FSM states and pixel type for the motion-estimation engine.
package me_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DRAIN, DONE} state_t;
  typedef logic [7:0] pixel_t;
  function automatic int n_cand(int search_dim, int blk_dim);
    return search_dim - blk_dim + 1;
  endfunction
  function automatic int mv_range(int search_dim, int blk_dim);
    return (search_dim - blk_dim) / 2;
  endfunction
  function automatic int sad_w(int pixel_w, int blk_dim);
    return pixel_w + 2 * $clog2(blk_dim);
  endfunction
  function automatic int mv_w(int search_dim, int blk_dim);
    return $clog2(search_dim - blk_dim + 1) + 1;
  endfunction
endpackage

// File: rtl/me_row_sad.sv
// me_row_sad: absolute differences of one row pair summed by a balanced adder tree.
module me_row_sad #(
  parameter int BLK_DIM = 16,
  parameter int PIXEL_W = 8,
  parameter int SAD_W = 16
) (
  input  logic [BLK_DIM*PIXEL_W-1:0] cur,
  input  logic [BLK_DIM*PIXEL_W-1:0] cand,
  output logic [SAD_W-1:0]           sad
);
  logic [SAD_W-1:0] node [2*BLK_DIM-1];
  logic [PIXEL_W-1:0] a, b;
  // heap layout: leaves at BLK_DIM-1.., node k sums children 2k+1 and 2k+2
  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < BLK_DIM; i++) begin
      a = cur[i*PIXEL_W +: PIXEL_W];
      b = cand[i*PIXEL_W +: PIXEL_W];
      node[BLK_DIM-1+i] = SAD_W'(a > b ? a - b : b - a);
    end
    for (int k = BLK_DIM - 2; k >= 0; k--) node[k] = node[2*k+1] + node[2*k+2];
  end
  assign sad = node[0];
endmodule

// File: rtl/me_full_search.sv
// me_full_search: full-search integer motion estimation returning min SAD, signed vector
// and an early-termination flag.
module me_full_search
  import me_pkg::*;
#(
  parameter int BLK_DIM = 16,
  parameter int SEARCH_DIM = 48,
  parameter int PIXEL_W = 8,
  localparam int SAD_W = sad_w(PIXEL_W, BLK_DIM),
  localparam int MV_W = mv_w(SEARCH_DIM, BLK_DIM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       ready,
  input  logic [SAD_W-1:0]           early_thr,
  input  logic                       cur_valid,
  output logic                       cur_ready,
  input  logic [BLK_DIM*PIXEL_W-1:0] cur_row,
  input  logic                       srch_valid,
  output logic                       srch_ready,
  input  logic [BLK_DIM*PIXEL_W-1:0] srch_row,
  output logic                       valid,
  output logic [SAD_W-1:0]           min_sad,
  output logic [MV_W-1:0]            mv_x,
  output logic [MV_W-1:0]            mv_y,
  output logic                       early_stop
);
  localparam int N = n_cand(SEARCH_DIM, BLK_DIM);
  localparam int CW = MV_W - 1;
  localparam int RW = $clog2(BLK_DIM);
  localparam logic [RW-1:0] LAST_R = RW'(BLK_DIM - 1);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
  localparam logic [MV_W-1:0] RNG = MV_W'(mv_range(SEARCH_DIM, BLK_DIM));
  state_t state, next;
  logic [BLK_DIM*PIXEL_W-1:0] cur_mem [BLK_DIM];
  logic [RW-1:0] lr, r;
  logic [CW-1:0] dx, dy, s1_dx, s1_dy, best_dx, best_dy;
  logic [SAD_W-1:0] thr, min_r, acc, row_sad, s1_sad, cand, new_min;
  logic s1_valid, s1_last, s2_done, early_hit, proc, better, cur_hs, srch_hs, last_beat;
  me_row_sad #(.BLK_DIM(BLK_DIM), .PIXEL_W(PIXEL_W), .SAD_W(SAD_W)) u_row_sad (
    .cur(cur_mem[r]), .cand(srch_row), .sad(row_sad)
  );
  assign ready = state == IDLE;
  assign cur_ready = state == LOAD;
  assign srch_ready = state == SEARCH;
  assign valid = state == DONE;
  assign cur_hs = cur_valid && cur_ready;
  assign srch_hs = srch_valid && srch_ready;
  assign last_beat = r == LAST_R && dx == LAST_C && dy == LAST_C;
  // once an early hit is registered, any beat still in stage 1 is discarded
  assign proc = s1_valid && !early_hit;
  assign cand = acc + s1_sad;
  assign better = cand < min_r;
  assign new_min = better ? cand : min_r;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? LOAD : IDLE;
      LOAD:    next = cur_hs && lr == LAST_R ? SEARCH : LOAD;
      SEARCH:  next = early_hit ? DONE : srch_hs && last_beat ? DRAIN : SEARCH;
      DRAIN:   next = s2_done ? DONE : DRAIN;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s1_valid <= 1'b0;
      s2_done <= 1'b0;
      early_hit <= 1'b0;
      min_sad <= '0;
      mv_x <= '0;
      mv_y <= '0;
      early_stop <= 1'b0;
    end else begin
      state <= next;
      s1_valid <= srch_hs;
      s1_sad <= row_sad;
      s1_last <= r == LAST_R;
      s1_dx <= dx;
      s1_dy <= dy;
      s2_done <= proc && s1_last;
      if (state == IDLE && start) begin
        thr <= early_thr;
        min_r <= '1;
        acc <= '0;
        lr <= '0;
        r <= '0;
        dx <= '0;
        dy <= '0;
        early_hit <= 1'b0;
      end
      if (cur_hs) begin
        cur_mem[lr] <= cur_row;
        lr <= lr + 1'b1;
      end
      if (srch_hs) begin
        r <= r + 1'b1;
        if (r == LAST_R) begin
          dx <= dx == LAST_C ? '0 : dx + 1'b1;
          if (dx == LAST_C) dy <= dy + 1'b1;
        end
      end
      if (proc) acc <= s1_last ? '0 : cand;
      if (proc && s1_last) begin
        if (better) begin
          min_r <= cand;
          best_dx <= s1_dx;
          best_dy <= s1_dy;
        end
        early_hit <= thr != '0 && new_min <= thr;
      end
      if (state != DONE && next == DONE) begin
        min_sad <= min_r;
        mv_x <= {1'b0, best_dx} - RNG;
        mv_y <= {1'b0, best_dy} - RNG;
        early_stop <= early_hit;
      end
    end
  end
endmodule

// File: tb/tb_me_full_search.sv
// tb_me_full_search: random-data scenarios against a direct SAD search model.
module tb_me_full_search;
  localparam int B = 4, S = 8, N = 5, RG = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic start = 0, ready, cur_valid = 0, cur_ready, srch_valid = 0, srch_ready, valid, early_stop;
  logic [11:0] early_thr = 0, min_sad;
  logic [31:0] cur_row = 0, srch_row = 0;
  logic [3:0] mv_x, mv_y;
  logic b_start = 0, b_ready, b_cur_valid = 0, b_cur_ready, b_srch_valid = 0, b_srch_ready, b_valid, b_early_stop;
  logic [15:0] b_early_thr = 0, b_min_sad;
  logic [127:0] b_cur_row = '1, b_srch_row = '0;
  logic [6:0] b_mv_x, b_mv_y;
  int total = 0, bad = 0, cyc = 0;
  int vtotal = 0, vcyc = 0, b_vtotal = 0, b_vcyc = 0;
  logic [11:0] c_sad;
  logic [3:0] c_mvx, c_mvy;
  logic c_es;
  logic [15:0] bc_sad;
  logic [6:0] bc_mvx, bc_mvy;
  logic bc_es;
  int blk [B][B];
  int win [S][S];

  me_full_search #(.BLK_DIM(4), .SEARCH_DIM(8), .PIXEL_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .early_thr(early_thr),
    .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_row(cur_row),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_row(srch_row),
    .valid(valid), .min_sad(min_sad), .mv_x(mv_x), .mv_y(mv_y), .early_stop(early_stop)
  );
  me_full_search u_big (
    .clk(clk), .rst(rst), .start(b_start), .ready(b_ready), .early_thr(b_early_thr),
    .cur_valid(b_cur_valid), .cur_ready(b_cur_ready), .cur_row(b_cur_row),
    .srch_valid(b_srch_valid), .srch_ready(b_srch_ready), .srch_row(b_srch_row),
    .valid(b_valid), .min_sad(b_min_sad), .mv_x(b_mv_x), .mv_y(b_mv_y), .early_stop(b_early_stop)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid === 1'b1) begin
    vtotal <= vtotal + 1; vcyc <= cyc; c_sad <= min_sad; c_mvx <= mv_x; c_mvy <= mv_y; c_es <= early_stop;
  end
  always @(negedge clk) if (b_valid === 1'b1) begin
    b_vtotal <= b_vtotal + 1; b_vcyc <= cyc; bc_sad <= b_min_sad; bc_mvx <= b_mv_x; bc_mvy <= b_mv_y; bc_es <= b_early_stop;
  end

  function automatic logic [31:0] cur_pack(int r);
    logic [31:0] v = '0;
    for (int j = 0; j < B; j++) v[j*8 +: 8] = 8'(blk[r][j]);
    return v;
  endfunction
  function automatic logic [31:0] cand_pack(int beat);
    logic [31:0] v = '0;
    int c = (beat / B) % (N * N), r = beat % B;
    for (int j = 0; j < B; j++) v[j*8 +: 8] = 8'(win[c / N + r][c % N + j]);
    return v;
  endfunction

  // Reference: exhaustive raster search, strict-less update, stop once min <= thr.
  task automatic model(input int thr, output int e_sad, output int e_dx, output int e_dy,
                       output bit e_early, output int e_idx);
    int s, d;
    bit stop = 0;
    e_sad = 32'h7fffffff; e_dx = 0; e_dy = 0; e_early = 0; e_idx = N * N - 1;
    for (int y = 0; y < N && !stop; y++)
      for (int x = 0; x < N && !stop; x++) begin
        s = 0;
        for (int r = 0; r < B; r++)
          for (int j = 0; j < B; j++) begin
            d = blk[r][j] - win[y + r][x + j];
            s += d < 0 ? -d : d;
          end
        if (s < e_sad) begin e_sad = s; e_dx = x; e_dy = y; end
        if (thr != 0 && e_sad <= thr) begin stop = 1; e_early = 1; e_idx = y * N + x; end
      end
  endtask

  task automatic run_small(input int thr, input bit gaps, input bit start_mid, input int abort_at,
                           output int beats, output int last_edge, output bit got, output int pulses);
    int r = 0, guard = 0, vb = vtotal;
    got = 0; last_edge = -1; pulses = 0; beats = 0;
    @(negedge clk); start = 1; early_thr = 12'(thr);
    @(negedge clk); start = 0;
    while (r < B && guard < 500) begin
      cur_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      cur_row = cur_pack(r);
      if (cur_valid && cur_ready) r++;
      guard++;
      @(negedge clk);
    end
    cur_valid = 0;
    while (srch_ready && guard < 5000 && !(abort_at > 0 && beats == abort_at)) begin
      srch_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      srch_row = cand_pack(beats);
      start = start_mid && beats >= 20 && beats < 24;
      if (srch_valid) begin
        if (beats == N * N * B - 1) last_edge = cyc + 1;
        beats++;
      end
      guard++;
      @(negedge clk);
    end
    srch_valid = 0; start = 0;
    if (abort_at == 0) begin
      guard = 0;
      while (vtotal == vb && guard < 50) begin @(negedge clk); guard++; end
      repeat (4) @(negedge clk);
      got = vtotal != vb;
      pulses = vtotal - vb;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b1 || b_ready !== 1'b1) begin bad++; $display("FAIL reset ready got %b/%b want 1", ready, b_ready); end
    total++; if (cur_ready !== 1'b0 || srch_ready !== 1'b0) begin bad++; $display("FAIL reset handshakes got %b%b want 00", cur_ready, srch_ready); end
    total++; if (valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL reset valid got %b/%b want 0", valid, b_valid); end
    total++; if (min_sad !== 12'd0 || b_min_sad !== 16'd0) begin bad++; $display("FAIL reset min_sad got %0d/%0d want 0", min_sad, b_min_sad); end
    total++; if (mv_x !== 4'd0 || mv_y !== 4'd0) begin bad++; $display("FAIL reset mv got %0d,%0d want 0,0", mv_x, mv_y); end
    total++; if (early_stop !== 1'b0) begin bad++; $display("FAIL reset early_stop got %b want 0", early_stop); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic check_run(input string tag, input int thr, input bit gaps, input bit start_mid);
    int e_sad, e_dx, e_dy, e_idx, beats, last_edge, pulses;
    bit e_early, got;
    model(thr, e_sad, e_dx, e_dy, e_early, e_idx);
    run_small(thr, gaps, start_mid, 0, beats, last_edge, got, pulses);
    total++; if (!got) begin bad++; $display("FAIL %s valid got none want pulse", tag); end
    total++; if (pulses != 1) begin bad++; $display("FAIL %s pulses got %0d want 1", tag, pulses); end
    total++; if (c_sad !== 12'(e_sad)) begin bad++; $display("FAIL %s min_sad got %0d want %0d", tag, c_sad, e_sad); end
    total++; if (c_mvx !== 4'(e_dx - RG) || c_mvy !== 4'(e_dy - RG)) begin bad++; $display("FAIL %s mv got %0d,%0d want %0d,%0d", tag, $signed(c_mvx), $signed(c_mvy), e_dx - RG, e_dy - RG); end
    total++; if (c_es !== e_early) begin bad++; $display("FAIL %s early_stop got %b want %b", tag, c_es, e_early); end
    if (e_early) begin
      total++; if (beats != e_idx * B + B + 2) begin bad++; $display("FAIL %s accepted beats got %0d want %0d", tag, beats, e_idx * B + B + 2); end
      total++; if (srch_ready !== 1'b0) begin bad++; $display("FAIL %s srch_ready got %b want 0", tag, srch_ready); end
    end else begin
      total++; if (beats != N * N * B) begin bad++; $display("FAIL %s beats got %0d want %0d", tag, beats, N * N * B); end
      total++; if (vcyc != last_edge + 2) begin bad++; $display("FAIL %s valid cycle got %0d want %0d", tag, vcyc, last_edge + 2); end
    end
  endtask

  task automatic test_exact_match;
    for (int y = 0; y < S; y++) for (int x = 0; x < S; x++) win[y][x] = $urandom_range(0, 255);
    for (int r = 0; r < B; r++) for (int j = 0; j < B; j++) blk[r][j] = win[1 + r][3 + j];
    check_run("exact", 0, 0, 0);
  endtask

  task automatic test_gaps;
    check_run("gaps", 0, 1, 0);
  endtask

  task automatic test_reset_mid_search;
    int beats, last_edge, pulses;
    bit got;
    run_small(0, 0, 0, 30, beats, last_edge, got, pulses);
    rst = 1;
    @(negedge clk);
    total++; if (min_sad !== 12'd0 || valid !== 1'b0) begin bad++; $display("FAIL midrst outputs got sad=%0d valid=%b want 0", min_sad, valid); end
    total++; if (mv_x !== 4'd0 || mv_y !== 4'd0 || early_stop !== 1'b0) begin bad++; $display("FAIL midrst mv got %0d,%0d es=%b want 0", mv_x, mv_y, early_stop); end
    total++; if (srch_ready !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL midrst ready got srch=%b idle=%b want 0/1", srch_ready, ready); end
    rst = 0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midrst ready after got %b want 1", ready); end
    check_run("rerun", 0, 0, 1);
  endtask

  task automatic test_tie;
    for (int y = 0; y < S; y++) for (int x = 0; x < S; x++) win[y][x] = 100;
    for (int y = 0; y < B; y++) for (int x = 0; x < B; x++) begin win[y][x] = 0; win[y + 4][x + 4] = 0; blk[y][x] = 0; end
    repeat (12) begin
      win[$urandom_range(0, 3)][$urandom_range(0, 3)] += 1;
      win[$urandom_range(4, 7)][$urandom_range(4, 7)] += 1;
    end
    check_run("tie", 0, 0, 0);
  endtask

  task automatic test_early_stop;
    for (int y = 0; y < S; y++) for (int x = 0; x < S; x++) win[y][x] = $urandom_range(0, 255);
    for (int r = 0; r < B; r++) for (int j = 0; j < B; j++) begin
      blk[r][j] = $urandom_range(50, 200);
      win[1 + r][2 + j] = blk[r][j];
    end
    win[1][2] += 5;
    check_run("early", 10, 0, 0);
  endtask

  task automatic test_defaults;
    int beats = 0, r = 0, guard = 0, last_edge = -1, vb = b_vtotal;
    @(negedge clk); b_start = 1;
    @(negedge clk); b_start = 0;
    while (r < 16 && guard < 100) begin
      b_cur_valid = 1;
      if (b_cur_ready) r++;
      guard++;
      @(negedge clk);
    end
    b_cur_valid = 0;
    guard = 0;
    while (b_srch_ready && guard < 20000) begin
      b_srch_valid = 1;
      if (beats == 1089 * 16 - 1) last_edge = cyc + 1;
      beats++;
      guard++;
      @(negedge clk);
    end
    b_srch_valid = 0;
    guard = 0;
    while (b_vtotal == vb && guard < 50) begin @(negedge clk); guard++; end
    repeat (4) @(negedge clk);
    total++; if (b_vtotal - vb != 1) begin bad++; $display("FAIL defaults pulses got %0d want 1", b_vtotal - vb); end
    total++; if (beats != 1089 * 16) begin bad++; $display("FAIL defaults beats got %0d want %0d", beats, 1089 * 16); end
    total++; if (bc_sad !== 16'(255 * 16 * 16)) begin bad++; $display("FAIL defaults min_sad got %0d want %0d", bc_sad, 255 * 256); end
    total++; if (bc_mvx !== 7'(-16) || bc_mvy !== 7'(-16)) begin bad++; $display("FAIL defaults mv got %0d,%0d want -16,-16", $signed(bc_mvx), $signed(bc_mvy)); end
    total++; if (bc_es !== 1'b0) begin bad++; $display("FAIL defaults early_stop got %b want 0", bc_es); end
    total++; if (b_vcyc != last_edge + 2) begin bad++; $display("FAIL defaults valid cycle got %0d want %0d", b_vcyc, last_edge + 2); end
  endtask

  initial begin
    test_reset;
    test_exact_match;
    test_gaps;
    test_reset_mid_search;
    test_tie;
    test_early_stop;
    test_defaults;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
